// File: rtl/seg_scan_scheduler.sv
// Two-digit (0-59) binary-to-BCD converter with a time-multiplexed digit scan for one shared decoder.
// Optional build macro SEG_SCAN_LEADING_BLANK_EN blanks the tens digit for values 0-9.
//
// state | meaning
// IDLE  | nothing loaded since reset, both digits blank, ready high
// CONV  | subtract-10 loop running, previous digits still shown, ready low
// SHOW  | digits committed and scanning, ready high for the next value
module seg_scan_scheduler #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [5:0] value,
  output logic       ready,
  output logic [3:0] bcd_out,
  output logic [1:0] dig_en_n,
  output logic       range_err
);

  typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       BLANK     = 4'hF;

  state_t           state, state_nx;
  logic [5:0]       rem, rem_nx;
  logic [2:0]       tens_acc, tens_acc_nx;
  logic [3:0]       tens_r, tens_nx;
  logic [3:0]       ones_r, ones_nx;
  logic             err_nx;
  logic [CNT_W-1:0] scan_cnt;
  logic             sel;
  logic             accept;

  assign ready  = (state != CONV);
  assign accept = load && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem       <= '0;
      tens_acc  <= '0;
      tens_r    <= BLANK;
      ones_r    <= BLANK;
      range_err <= 1'b0;
    end else begin
      state     <= state_nx;
      rem       <= rem_nx;
      tens_acc  <= tens_acc_nx;
      tens_r    <= tens_nx;
      ones_r    <= ones_nx;
      range_err <= err_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    rem_nx      = rem;
    tens_acc_nx = tens_acc;
    tens_nx     = tens_r;
    ones_nx     = ones_r;
    err_nx      = range_err;
    case (state)
      IDLE, SHOW: begin
        if (accept) begin
          if (value <= 6'd59) begin
            rem_nx      = value;
            tens_acc_nx = 3'd0;
            state_nx    = CONV;
          end else begin
            tens_nx  = BLANK;
            ones_nx  = BLANK;
            err_nx   = 1'b1;
            state_nx = SHOW;
          end
        end
      end
      CONV: begin
        if (rem >= 6'd10) begin
          rem_nx      = rem - 6'd10;
          tens_acc_nx = tens_acc + 3'd1;
        end else begin
          // Both digits change on the same edge so the display never shows a mixed value.
          tens_nx = {1'b0, tens_acc};
`ifdef SEG_SCAN_LEADING_BLANK_EN
          if (tens_acc == 3'd0) tens_nx = BLANK;
`endif
          ones_nx  = rem[3:0];
          err_nx   = 1'b0;
          state_nx = SHOW;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Scan runs in every state; outputs are registered together so enable and digit stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      sel      <= 1'b0;
      bcd_out  <= BLANK;
      dig_en_n <= 2'b10;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        sel      <= ~sel;
      end else begin
        scan_cnt <= scan_cnt + CNT_ONE;
      end
      bcd_out  <= sel ? tens_r : ones_r;
      dig_en_n <= sel ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Scoreboard bench for seg_scan_scheduler: loads push expected digits/latency, a monitor checks display.
module tb_seg_scan_scheduler;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [5:0] value = '0;
  logic       ready;
  logic [3:0] bcd_out;
  logic [1:0] dig_en_n;
  logic       range_err;

  typedef struct {
    logic [3:0] t;
    logic [3:0] o;
    logic       err;
    int         busy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_edge = 0;

  seg_scan_scheduler #(.SCAN_DIV(SD), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value),
    .ready(ready), .bcd_out(bcd_out), .dig_en_n(dig_en_n), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int v);
    exp_t e;
    if (v > 59) begin
      e.t = 4'hF; e.o = 4'hF; e.err = 1'b1; e.busy = 0;
    end else begin
      e.t = 4'(v / 10);
`ifdef SEG_SCAN_LEADING_BLANK_EN
      if (v < 10) e.t = 4'hF;
`endif
      e.o = 4'(v % 10); e.err = 1'b0; e.busy = v / 10 + 1;
    end
    return e;
  endfunction

  task automatic chk_disp(input logic [3:0] t, input logic [3:0] o, input string name);
    if (dig_en_n == 2'b10) chk({name, "_ones"}, bcd_out, o);
    else                   chk({name, "_tens"}, bcd_out, t);
  endtask

  // Scan slots are a pure function of clocks since reset release.
  always @(posedge clk) begin
    if (!rst_n) n_edge <= 0;
    else        n_edge <= n_edge + 1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", ready, 1);
      chk("rst_bcd", bcd_out, 4'hF);
      chk("rst_dig", dig_en_n, 2'b10);
      chk("rst_err", range_err, 0);
    end else begin
      chk("dig_en_n", dig_en_n,
          (n_edge == 0) ? 2'b10 : ((((n_edge - 1) / SD) % 2) != 0 ? 2'b01 : 2'b10));
    end
  end

  initial begin : monitor
    exp_t       e;
    logic [3:0] pt;
    logic [3:0] po;
    logic       pe;
    int         busy;
    bit         aborted;
    pt = 4'hF; po = 4'hF; pe = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pt = 4'hF; po = 4'hF; pe = 1'b0;
      end else if (load && ready) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          e = sb.pop_front();
          busy = 0;
          aborted = 0;
          forever begin
            @(negedge clk);
            if (!rst_n) begin aborted = 1; break; end
            if (ready) break;
            busy++;
            chk_disp(pt, po, "hold");
            chk("hold_err", range_err, pe);
            if (busy > 12) begin chk("busy_timeout", busy, e.busy); break; end
          end
          if (aborted) begin
            sb.delete();
            pt = 4'hF; po = 4'hF; pe = 1'b0;
            for (int k = 0; k < 50 && !rst_n; k++) @(negedge clk);
            chk("rst_release_timeout", rst_n, 1);
            for (int i = 0; i < 2 * SD; i++) begin
              @(negedge clk);
              chk_disp(4'hF, 4'hF, "post_rst");
              chk("post_rst_ready", ready, 1);
            end
          end else begin
            chk("busy_cycles", busy, e.busy);
            chk_disp(pt, po, "pre_commit");
            for (int i = 0; i < 2 * SD; i++) begin
              @(negedge clk);
              chk_disp(e.t, e.o, "show");
              chk("show_err", range_err, e.err);
            end
            pt = e.t; po = e.o; pe = e.err;
          end
        end
      end
    end
  end

  task automatic do_load(input logic [5:0] v);
    @(posedge clk);
    #1;
    if (ready) sb.push_back(model(v));
    load  = 1'b1;
    value = v;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin : stimulus
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    gap(12);
    do_load(6'd47); gap(20);
    do_load(6'd0);  gap(20);
    do_load(6'd12); gap(20);
    do_load(6'd59);
    do_load(6'd3);  gap(20);
    do_load(6'd63); gap(20);
    do_load(6'd25); gap(20);
    do_load(6'd38);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    gap(3);
    #1 rst_n = 1'b1;
    gap(20);
    for (int i = 0; i < 25; i++) begin
      do_load(6'($urandom_range(0, 63)));
      gap(18 + $urandom_range(0, 5));
    end
    gap(10);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
